dual_port_sram_ex: RTL and testbench

Parametrised true dual-port synchronous SRAM; successor to the fixed 16x16 dual-port SRAM. Adds byte-enable writes, selectable read latency, a defined read-during-write mode, deterministic same-address write-collision resolution with a collision counter, and a hardware zero-initialisation sweep after reset. It serves as the shared scratch/buffer memory between two independent masters on one clock.

---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_port_pipe.sv | 53 +++++
 rtl/dual_port_sram_ex.sv | 150 +++++++++++++++
 tb/tb_dual_port_sram_ex.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the dual-port scratch SRAM.
// Holds the init/ready state encoding, read-during-write mode codes and the read latency legality check.
package sram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    function automatic bit read_lat_ok(input int lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/sram_port_pipe.sv
// Per-port read pipeline: one or two register stages between the array read and data_out/valid.
// data_out only reloads when a read completes, so it holds the last read value between reads.
module sram_port_pipe #(
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] data_out,
    output logic              valid
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= req;
            if (req) begin
                s1_data <= rd_data;
            end
        end
    end

    if (READ_LAT == 1) begin : g_lat1
        assign data_out = s1_data;
        assign valid    = s1_valid;
    end else begin : g_lat2
        logic              s2_valid;
        logic [DATA_W-1:0] s2_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign data_out = s2_data;
        assign valid    = s2_valid;
    end

endmodule

// File: rtl/dual_port_sram_ex.sv
// True dual-port synchronous SRAM with byte enables, zero-init sweep after reset,
// selectable read-during-write behaviour and deterministic write-collision merging.
module dual_port_sram_ex
    import sram_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int READ_LAT = 1,
    parameter int RDW_MODE = 0,
    parameter int PRIO_A   = 1,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_a,
    input  logic                enable_b,
    input  logic                we_a,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   data_in_a,
    input  logic [DATA_W-1:0]   data_in_b,
    output logic [DATA_W-1:0]   data_out_a,
    output logic [DATA_W-1:0]   data_out_b,
    output logic                valid_a,
    output logic                valid_b,
    output logic                busy,
    output logic                collision,
    output logic [CNT_W-1:0]    collision_cnt,
    output state_t              state
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
        $error("dual_port_sram_ex: READ_LAT must be 1 or 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    state_t            state_nx;

    logic              ready;
    logic              wr_a, wr_b, rd_a, rd_b, coll_hit;
    logic [DATA_W-1:0] rdata_a, rdata_b;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [NB-1:0]     be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        ready    = (state == READY);
        wr_a     = ready && enable_a && we_a;
        wr_b     = ready && enable_b && we_b;
        rd_a     = ready && enable_a && !we_a;
        rd_b     = ready && enable_b && !we_b;
        // A collision needs both ports actually modifying the same word.
        coll_hit = wr_a && wr_b && (addr_a == addr_b) && (|be_a) && (|be_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    if (ptr == ADDR_W'(DEPTH - 1)) state_nx = READY;
            READY:   state_nx = READY;
            default: state_nx = INIT;
        endcase
    end

    assign busy = (state == INIT);

    // Storage is not reset; the sweep clears it. Within a byte lane the winner's write is issued last.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[ptr] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (PRIO_A != 0) begin
                    if (wr_b && be_b[i]) mem[addr_b][i*8 +: 8] <= data_in_b[i*8 +: 8];
                    if (wr_a && be_a[i]) mem[addr_a][i*8 +: 8] <= data_in_a[i*8 +: 8];
                end else begin
                    if (wr_a && be_a[i]) mem[addr_a][i*8 +: 8] <= data_in_a[i*8 +: 8];
                    if (wr_b && be_b[i]) mem[addr_b][i*8 +: 8] <= data_in_b[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_a = mem[addr_a];
        rdata_b = mem[addr_b];
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            if (wr_b && (addr_b == addr_a)) rdata_a = merge_bytes(mem[addr_a], data_in_b, be_b);
            if (wr_a && (addr_a == addr_b)) rdata_b = merge_bytes(mem[addr_b], data_in_a, be_a);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision     <= 1'b0;
            collision_cnt <= '0;
        end else begin
            collision <= coll_hit;
            if (coll_hit && (collision_cnt != {CNT_W{1'b1}})) begin
                collision_cnt <= collision_cnt + 1'b1;
            end
        end
    end

    sram_port_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_pipe_a (
        .clk      (clk),
        .rst      (rst),
        .req      (rd_a),
        .rd_data  (rdata_a),
        .data_out (data_out_a),
        .valid    (valid_a)
    );

    sram_port_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_pipe_b (
        .clk      (clk),
        .rst      (rst),
        .req      (rd_b),
        .rd_data  (rdata_b),
        .data_out (data_out_b),
        .valid    (valid_b)
    );

endmodule

// File: tb/tb_dual_port_sram_ex.sv
// Directed bench for dual_port_sram_ex: a read-latency-1 read-first instance and a
// read-latency-2 write-first instance driven by the same stimulus.
module tb_dual_port_sram_ex;
    import sram_pkg::*;

    logic        clk, rst;
    logic        enable_a, enable_b, we_a, we_b;
    logic [1:0]  be_a, be_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] data_in_a, data_in_b;

    logic [15:0] do_a1, do_b1, do_a2, do_b2;
    logic        v_a1, v_b1, v_a2, v_b2;
    logic        busy1, busy2, coll1, coll2;
    logic [7:0]  cnt1, cnt2;
    state_t      st1, st2;

    int checks = 0;
    int errors = 0;

    dual_port_sram_ex #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1), .RDW_MODE(0), .PRIO_A(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .enable_a(enable_a), .enable_b(enable_b), .we_a(we_a), .we_b(we_b),
        .be_a(be_a), .be_b(be_b), .addr_a(addr_a), .addr_b(addr_b),
        .data_in_a(data_in_a), .data_in_b(data_in_b), .data_out_a(do_a1), .data_out_b(do_b1),
        .valid_a(v_a1), .valid_b(v_b1), .busy(busy1), .collision(coll1), .collision_cnt(cnt1), .state(st1)
    );

    dual_port_sram_ex #(.DATA_W(16), .ADDR_W(4), .READ_LAT(2), .RDW_MODE(1), .PRIO_A(1), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .enable_a(enable_a), .enable_b(enable_b), .we_a(we_a), .we_b(we_b),
        .be_a(be_a), .be_b(be_b), .addr_a(addr_a), .addr_b(addr_b),
        .data_in_a(data_in_a), .data_in_b(data_in_b), .data_out_a(do_a2), .data_out_b(do_b2),
        .valid_a(v_a2), .valid_b(v_b2), .busy(busy2), .collision(coll2), .collision_cnt(cnt2), .state(st2)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en_a, we_a; logic [1:0] be_a; logic [3:0] addr_a; logic [15:0] din_a;
        logic        en_b, we_b; logic [1:0] be_b; logic [3:0] addr_b; logic [15:0] din_b;
        logic        ev_a; logic [15:0] ed_a0, ed_a1;
        logic        ev_b; logic [15:0] ed_b0, ed_b1;
        logic        ecoll; logic [7:0] ecnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(
        input logic ea, input logic wa, input logic [1:0] ba, input logic [3:0] aa, input logic [15:0] da,
        input logic eb, input logic wb, input logic [1:0] bb, input logic [3:0] ab, input logic [15:0] db,
        input logic eva, input logic [15:0] eda0, input logic [15:0] eda1,
        input logic evb, input logic [15:0] edb0, input logic [15:0] edb1,
        input logic ecoll, input logic [7:0] ecnt);
        vec_t v;
        v.en_a = ea; v.we_a = wa; v.be_a = ba; v.addr_a = aa; v.din_a = da;
        v.en_b = eb; v.we_b = wb; v.be_b = bb; v.addr_b = ab; v.din_b = db;
        v.ev_a = eva; v.ed_a0 = eda0; v.ed_a1 = eda1;
        v.ev_b = evb; v.ed_b0 = edb0; v.ed_b1 = edb1;
        v.ecoll = ecoll; v.ecnt = ecnt;
        return v;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        enable_a = 0; enable_b = 0; we_a = 0; we_b = 0; be_a = 0; be_b = 0;
        addr_a = 0; addr_b = 0; data_in_a = 0; data_in_b = 0;
    endtask

    task automatic apply(input vec_t v);
        enable_a = v.en_a; we_a = v.we_a; be_a = v.be_a; addr_a = v.addr_a; data_in_a = v.din_a;
        enable_b = v.en_b; we_b = v.we_b; be_b = v.be_b; addr_b = v.addr_b; data_in_b = v.din_b;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_init(input string tag);
        int  n;
        bit  saw_valid;
        n = 0;
        saw_valid = 0;
        while (busy1 && n < 40) begin
            tick();
            n++;
            if (v_a1 || v_b1 || v_a2 || v_b2 || coll1 || coll2) saw_valid = 1;
        end
        chk({tag, "_init_edges"}, n, 16);
        chk({tag, "_init_quiet"}, 32'(saw_valid), 0);
        chk({tag, "_busy2_low"}, 32'(busy2), 0);
        chk({tag, "_state_ready"}, 32'(st1), 32'(READY));
    endtask

    initial begin
        vec_t p;

        vecs[0]  = mk(1,0,0,0,16'h0,      1,0,0,15,16'h0,     1,16'h0,16'h0,       1,16'h0,16'h0,       0,0);
        vecs[1]  = mk(1,0,0,3,16'h0,      1,0,0,3,16'h0,      1,16'h0,16'h0,       1,16'h0,16'h0,       0,0);
        vecs[2]  = mk(1,1,3,4,16'hA5A5,   0,0,0,0,16'h0,      0,16'h0,16'h0,       0,16'h0,16'h0,       0,0);
        vecs[3]  = mk(1,1,1,4,16'h0011,   1,0,0,4,16'h0,      0,16'h0,16'h0,       1,16'hA5A5,16'hA511, 0,0);
        vecs[4]  = mk(1,0,0,7,16'h0,      1,0,0,4,16'h0,      1,16'h0,16'h0,       1,16'hA511,16'hA511, 0,0);
        vecs[5]  = mk(1,1,2,6,16'hFACE,   1,1,3,6,16'hDEAD,   0,16'h0,16'h0,       0,16'h0,16'h0,       1,1);
        vecs[6]  = mk(1,0,0,6,16'h0,      1,1,3,10,16'h1234,  1,16'hFAAD,16'hFAAD, 0,16'h0,16'h0,       0,1);
        vecs[7]  = mk(1,1,3,10,16'hC0FF,  1,0,0,10,16'h0,     0,16'h0,16'h0,       1,16'h1234,16'hC0FF, 0,1);
        vecs[8]  = mk(1,0,0,10,16'h0,     1,0,0,10,16'h0,     1,16'hC0FF,16'hC0FF, 1,16'hC0FF,16'hC0FF, 0,1);
        vecs[9]  = mk(1,1,0,9,16'hFFFF,   1,1,0,9,16'hFFFF,   0,16'h0,16'h0,       0,16'h0,16'h0,       0,1);
        vecs[10] = mk(1,0,0,9,16'h0,      0,0,0,0,16'h0,      1,16'h0,16'h0,       0,16'h0,16'h0,       0,1);
        vecs[11] = mk(1,1,1,12,16'h1122,  1,1,2,12,16'h3344,  0,16'h0,16'h0,       0,16'h0,16'h0,       1,2);
        vecs[12] = mk(1,0,0,12,16'h0,     1,0,0,6,16'h0,      1,16'h3322,16'h3322, 1,16'hFAAD,16'hFAAD, 0,2);
        vecs[13] = mk(0,0,0,0,16'h0,      0,0,0,0,16'h0,      0,16'h0,16'h0,       0,16'h0,16'h0,       0,2);
        vecs[14] = mk(0,0,0,0,16'h0,      0,0,0,0,16'h0,      0,16'h0,16'h0,       0,16'h0,16'h0,       0,2);

        // Reset state
        set_idle();
        rst = 1;
        tick();
        tick();
        chk("rst_busy1", 32'(busy1), 1);
        chk("rst_busy2", 32'(busy2), 1);
        chk("rst_state", 32'(st1), 32'(INIT));
        chk("rst_valid", {28'b0, v_a1, v_b1, v_a2, v_b2}, 0);
        chk("rst_dout1", {do_a1, do_b1}, 0);
        chk("rst_dout2", {do_a2, do_b2}, 0);
        chk("rst_coll", {30'b0, coll1, coll2}, 0);
        chk("rst_cnt", {cnt1, cnt2}, 0);

        // Requests during the sweep must be ignored
        enable_a = 1; we_a = 1; be_a = 2'b11; addr_a = 3; data_in_a = 16'hFFFF;
        enable_b = 1; we_b = 0; addr_b = 3;
        rst = 0;
        wait_init("first");
        set_idle();

        // Table-driven phase; instance 2 is checked against the previous row's write-first data
        p = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0);
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i]);
            tick();
            chk($sformatf("v%0d_va1", i), 32'(v_a1), 32'(vecs[i].ev_a));
            chk($sformatf("v%0d_vb1", i), 32'(v_b1), 32'(vecs[i].ev_b));
            if (vecs[i].ev_a) chk($sformatf("v%0d_da1", i), 32'(do_a1), 32'(vecs[i].ed_a0));
            if (vecs[i].ev_b) chk($sformatf("v%0d_db1", i), 32'(do_b1), 32'(vecs[i].ed_b0));
            chk($sformatf("v%0d_coll1", i), 32'(coll1), 32'(vecs[i].ecoll));
            chk($sformatf("v%0d_cnt1", i), 32'(cnt1), 32'(vecs[i].ecnt));
            chk($sformatf("v%0d_va2", i), 32'(v_a2), 32'(p.ev_a));
            chk($sformatf("v%0d_vb2", i), 32'(v_b2), 32'(p.ev_b));
            if (p.ev_a) chk($sformatf("v%0d_da2", i), 32'(do_a2), 32'(p.ed_a1));
            if (p.ev_b) chk($sformatf("v%0d_db2", i), 32'(do_b2), 32'(p.ed_b1));
            chk($sformatf("v%0d_coll2", i), 32'(coll2), 32'(vecs[i].ecoll));
            chk($sformatf("v%0d_cnt2", i), 32'(cnt2), 32'(vecs[i].ecnt));
            p = vecs[i];
        end
        set_idle();
        tick();

        // data_out holds the last read value across idle cycles
        chk("hold_da1", 32'(do_a1), 32'h3322);
        chk("hold_db1", 32'(do_b1), 32'hFAAD);
        chk("hold_da2", 32'(do_a2), 32'h3322);
        chk("hold_db2", 32'(do_b2), 32'hFAAD);

        // 300 collisions on addr 1: counter saturates
        enable_a = 1; we_a = 1; be_a = 2'b11; addr_a = 1; data_in_a = 16'h1111;
        enable_b = 1; we_b = 1; be_b = 2'b11; addr_b = 1; data_in_b = 16'h2222;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_coll_pulse", 32'(coll1), 1);
        set_idle();
        tick();
        chk("sat_cnt1", 32'(cnt1), 255);
        chk("sat_cnt2", 32'(cnt2), 255);
        chk("sat_coll_low", {30'b0, coll1, coll2}, 0);
        enable_a = 1; addr_a = 1;
        tick();
        set_idle();
        chk("sat_win_a1", {15'b0, v_a1, do_a1}, {15'b0, 1'b1, 16'h1111});
        tick();
        chk("sat_win_a2", {15'b0, v_a2, do_a2}, {15'b0, 1'b1, 16'h1111});

        // Reset one cycle after a read: the latency-2 result must never appear
        enable_a = 1; addr_a = 12;
        tick();
        rst = 1;
        set_idle();
        #1;
        chk("mid_rst_valid", {28'b0, v_a1, v_b1, v_a2, v_b2}, 0);
        tick();
        chk("mid_rst_valid_late", {30'b0, v_a2, v_b2}, 0);
        chk("mid_rst_cnt", {cnt1, cnt2}, 0);
        chk("mid_rst_busy", {30'b0, busy1, busy2}, 2'b11);
        chk("mid_rst_state", 32'(st2), 32'(INIT));
        rst = 0;
        wait_init("second");
        enable_a = 1; addr_a = 12;
        tick();
        set_idle();
        chk("resweep_a1", {15'b0, v_a1, do_a1}, {15'b0, 1'b1, 16'h0000});
        tick();
        chk("resweep_a2", {15'b0, v_a2, do_a2}, {15'b0, 1'b1, 16'h0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
